// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults and helpers for the clock divider
package clk_div_pkg;

    localparam int PKG_CNT_W   = 16;
    localparam int PKG_DEF_DIV = 4;

    // ceil(d/2) evaluated one bit wider than any supported divisor so d+1 never overflows
    function automatic logic [32:0] half_up(input logic [32:0] d);
        return (d + 33'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel with shadow divisor, tick enable and square-wave output
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = PKG_CNT_W,
    parameter int DEF_DIV = PKG_DEF_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             load,
    output logic             tick,
    output logic             clk_out,
    output logic             busy
);

    localparam int XW = 33 - CNT_W;

    logic [CNT_W-1:0] cnt, d, s, cnt_nxt, d_nxt;
    logic             pend, wrap, apply, hi;

    assign busy = pend;

    // wrap/apply decisions; clk_out phase uses the divisor in force after this edge
    always_comb begin
        wrap    = (d != '0) && ({1'b0, cnt} == {1'b0, d} - {{CNT_W{1'b0}}, 1'b1});
        apply   = pend && ((d == '0) || (en && wrap));
        d_nxt   = apply ? s : d;
        cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
        hi      = (d_nxt != CNT_W'(1)) && ({{XW{1'b0}}, cnt_nxt} < half_up({{XW{1'b0}}, d_nxt}));
    end

    // counter, shadow capture, divisor apply and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            d       <= CNT_W'(DEF_DIV);
            s       <= CNT_W'(DEF_DIV);
            pend    <= 1'b0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            if (load) s <= div_val;
            pend <= load | (pend & ~apply);
            if (apply) d <= s;
            if (d == '0) begin
                cnt     <= '0;
                tick    <= 1'b0;
                clk_out <= 1'b0;
            end else if (en) begin
                cnt     <= cnt_nxt;
                tick    <= wrap;
                clk_out <= hi;
            end else begin
                tick    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: N_CH independent runtime-programmable clock-enable/divided-clock channels
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int CNT_W   = PKG_CNT_W,
    parameter int DEF_DIV = PKG_DEF_DIV
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [N_CH*CNT_W-1:0] div_val,
    input  logic [N_CH-1:0]       load,
    output logic [N_CH-1:0]       tick,
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       busy
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .div_val (div_val[g*CNT_W +: CNT_W]),
            .load    (load[g]),
            .tick    (tick[g]),
            .clk_out (clk_out[g]),
            .busy    (busy[g])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed checks of the two-channel divider, sampled on falling edges
module tb_clk_div_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [31:0] div_val = '0;
    logic [1:0]  load = '0;
    logic [1:0]  tick, clk_out, busy;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    clk_div_gen #(
        .N_CH    (2),
        .CNT_W   (16),
        .DEF_DIV (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .div_val (div_val),
        .load    (load),
        .tick    (tick),
        .clk_out (clk_out),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // one character per falling edge: '1' high, '0' low; empty string skips that channel
    task automatic cyc(input string tag, input string t0, input string c0, input string t1, input string c1);
        int n;
        n = (t0.len() > 0) ? t0.len() : t1.len();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (t0.len() > 0) begin
                chk($sformatf("%s_tick0[%0d]", tag, i), {1'b0, tick[0]}, {1'b0, t0[i] == "1"});
                chk($sformatf("%s_clk0[%0d]", tag, i), {1'b0, clk_out[0]}, {1'b0, c0[i] == "1"});
            end
            if (t1.len() > 0) begin
                chk($sformatf("%s_tick1[%0d]", tag, i), {1'b0, tick[1]}, {1'b0, t1[i] == "1"});
                chk($sformatf("%s_clk1[%0d]", tag, i), {1'b0, clk_out[1]}, {1'b0, c1[i] == "1"});
            end
        end
    endtask

    initial begin
        #2 reset = 1'b0;
        en = 1'b1;
        @(negedge clk);
        chk("rst_tick", tick, 2'b00);
        chk("rst_clk", clk_out, 2'b00);
        chk("rst_busy", busy, 2'b00);
        @(negedge clk);
        chk("rst_tick2", tick, 2'b00);
        chk("rst_clk2", clk_out, 2'b00);
        reset = 1'b1;
        cyc("dflt", "000100010001", "100110011001", "000100010001", "100110011001");

        div_val[31:16] = 16'd5;
        load = 2'b10;
        @(negedge clk);
        load = '0;
        chk("ld5_busy", busy, 2'b10);
        cyc("ld5a", "00", "00", "00", "00");
        chk("ld5_busy2", busy, 2'b10);
        cyc("ld5b", "10001000100", "11001100110", "10000100001", "11100111001");
        chk("ld5_busy_clr", busy, 2'b00);

        repeat (2) @(negedge clk);
        div_val[15:0] = 16'd6;
        load = 2'b01;
        @(negedge clk);
        div_val[15:0] = 16'd10;
        @(negedge clk);
        load = '0;
        chk("ld10_busy", busy, 2'b01);
        cyc("ld10", "010000000001", "011111000001", "", "");
        chk("ld10_busy_clr", busy, 2'b00);

        div_val[15:0] = 16'd0;
        load = 2'b01;
        @(negedge clk);
        load = '0;
        cyc("ld0", "000000001000", "111000000000", "", "");

        div_val[15:0] = 16'd3;
        load = 2'b01;
        @(negedge clk);
        load = '0;
        en = 1'b0;
        chk("ld3_busy", busy, 2'b01);
        cyc("ld3_off", "0", "0", "", "");
        chk("ld3_busy_clr", busy, 2'b00);
        en = 1'b1;
        cyc("ld3", "001001", "101101", "", "");

        div_val[15:0] = 16'd4;
        load = 2'b01;
        @(negedge clk);
        load = '0;
        cyc("ld4", "01", "01", "", "");
        en = 1'b0;
        cyc("hold", "0000000", "1111111", "", "");
        en = 1'b1;
        cyc("resume", "0001", "1001", "", "");

        div_val[15:0] = 16'd1;
        load = 2'b01;
        @(negedge clk);
        load = '0;
        cyc("ld1", "0011111", "0000000", "", "");

        div_val[31:16] = 16'd7;
        load = 2'b10;
        @(negedge clk);
        load = '0;
        chk("ld7_busy", busy, 2'b10);
        #2 reset = 1'b0;
        #1;
        chk("arst_tick", tick, 2'b00);
        chk("arst_clk", clk_out, 2'b00);
        chk("arst_busy", busy, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        cyc("rel", "00010", "10011", "00010", "10011");
        chk("rel_busy", busy, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
